// File: rtl/booth_mult_param.sv
// Iterative Booth multiplier with parallel operand load, signed/unsigned modes and a one-cycle done pulse.
// Define BOOTH_RADIX4_EN to retire two multiplier bits per cycle with radix-4 modified Booth recoding.
module booth_mult_param #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  generate
    if ((WIDTH < 4) || (WIDTH > 64)) begin : g_bad_width
      $error("booth_mult_param: WIDTH must be in 4..64");
    end
  endgenerate

`ifdef BOOTH_RADIX4_EN
  // Q holds the even-rounded operand width; A carries one extra bit so 2M fits.
  localparam int QW     = WIDTH + 2;
  localparam int AW     = QW + 1;
  localparam int NS     = WIDTH + (WIDTH % 2);
  localparam int NU     = (WIDTH + 1) + ((WIDTH + 1) % 2);
  localparam int ITER_S = NS / 2;
  localparam int ITER_U = NU / 2;
`else
  localparam int QW     = WIDTH + 1;
  localparam int AW     = QW;
  localparam int NS     = WIDTH;
  localparam int NU     = WIDTH + 1;
  localparam int ITER_S = NS;
  localparam int ITER_U = NU;
`endif
  localparam int CW   = $clog2(WIDTH + 2);
  // Product sits in {A,Q} above the multiplier bits that were never shifted out.
  localparam int SH_S = QW - NS;
  localparam int SH_U = QW - NU;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [AW-1:0]   a, m, sum, a_nxt;
  logic [QW-1:0]   q, q_nxt;
  logic            qm1, qm1_nxt, sm;
  logic [CW-1:0]   count;
  logic [AW+QW-1:0] full;
  logic [2*WIDTH-1:0] prod_nxt;
  logic            m_ext, q_ext;

  assign m_ext = signed_mode & multiplicand[WIDTH-1];
  assign q_ext = signed_mode & multiplier[WIDTH-1];

  always_comb begin
    sum = a;
`ifdef BOOTH_RADIX4_EN
    case ({q[1:0], qm1})
      3'b001, 3'b010: sum = a + m;
      3'b011:         sum = a + (m << 1);
      3'b100:         sum = a - (m << 1);
      3'b101, 3'b110: sum = a - m;
      default:        sum = a;
    endcase
    a_nxt   = {{2{sum[AW-1]}}, sum[AW-1:2]};
    q_nxt   = {sum[1:0], q[QW-1:2]};
    qm1_nxt = q[1];
`else
    case ({q[0], qm1})
      2'b01:   sum = a + m;
      2'b10:   sum = a - m;
      default: sum = a;
    endcase
    a_nxt   = {sum[AW-1], sum[AW-1:1]};
    q_nxt   = {sum[0], q[QW-1:1]};
    qm1_nxt = q[0];
`endif
    full     = {a_nxt, q_nxt};
    prod_nxt = (2*WIDTH)'(full >> (sm ? SH_S : SH_U));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      count   <= '0;
      a       <= '0;
      q       <= '0;
      qm1     <= 1'b0;
      m       <= '0;
      sm      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a     <= '0;
            q     <= {{(QW-WIDTH){q_ext}}, multiplier};
            qm1   <= 1'b0;
            m     <= {{(AW-WIDTH){m_ext}}, multiplicand};
            sm    <= signed_mode;
            count <= signed_mode ? CW'(ITER_S) : CW'(ITER_U);
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a     <= a_nxt;
          q     <= q_nxt;
          qm1   <= qm1_nxt;
          count <= count - 1'b1;
          if (count == CW'(1)) begin
            product <= prod_nxt;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_param.sv
// Bench for booth_mult_param: WIDTH=16 directed cases plus a WIDTH=8 random run, both checked every cycle
// against a cycle-level model built on plain integer multiplication.
module tb_booth_mult_param;

  logic        clk, rst;
  logic        s16, sm16, busy16, done16;
  logic [15:0] m16, q16;
  logic [31:0] product16;
  logic        s8, sm8, busy8, done8;
  logic [7:0]  m8, q8;
  logic [15:0] product8;

  int nvec = 0, nerr = 0, ncomp8 = 0;
  bit chk_en = 0;

  bit          mb[2], md[2];
  int          mr[2];
  logic [63:0] mp[2], mpend[2];

  booth_mult_param #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(s16), .signed_mode(sm16),
    .multiplicand(m16), .multiplier(q16),
    .busy(busy16), .done(done16), .product(product16));

  booth_mult_param #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(s8), .signed_mode(sm8),
    .multiplicand(m8), .multiplier(q8),
    .busy(busy8), .done(done8), .product(product8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat(int w, bit sm);
    int n;
    n = sm ? w : w + 1;
`ifdef BOOTH_RADIX4_EN
    n = (n + n % 2) / 2;
`endif
    return n;
  endfunction

  function automatic logic [63:0] mulx(int w, bit sm, logic [63:0] m, logic [63:0] q);
    longint a, b, p;
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    a = longint'(m & mask);
    b = longint'(q & mask);
    if (sm) begin
      a = (a <<< (64 - w)) >>> (64 - w);
      b = (b <<< (64 - w)) >>> (64 - w);
    end
    p = a * b;
    return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  task automatic step(int i, int w, bit rs, bit st, bit sm, logic [63:0] m, logic [63:0] q);
    if (rs) begin
      mb[i] = 0; md[i] = 0; mp[i] = '0; mr[i] = 0;
    end else begin
      md[i] = 0;
      if (mb[i]) begin
        mr[i]--;
        if (mr[i] == 0) begin
          mb[i] = 0; md[i] = 1; mp[i] = mpend[i];
          if (i == 1) ncomp8++;
        end
      end else if (st) begin
        mb[i] = 1; mr[i] = lat(w, sm); mpend[i] = mulx(w, sm, m, q);
      end
    end
  endtask

  always @(posedge clk) begin
    step(0, 16, rst, s16, sm16, 64'(m16), 64'(q16));
    step(1, 8,  rst, s8,  sm8,  64'(m8),  64'(q8));
  end

  always @(negedge clk) begin
    if (chk_en) begin
      nvec++;
      if (busy16 !== mb[0] || done16 !== md[0] || product16 !== mp[0][31:0]) begin
        nerr++;
        $display("FAIL w16_cycle t=%0t: busy=%b done=%b product=%h, required busy=%b done=%b product=%h",
                 $time, busy16, done16, product16, mb[0], md[0], mp[0][31:0]);
      end
      nvec++;
      if (busy8 !== mb[1] || done8 !== md[1] || product8 !== mp[1][15:0]) begin
        nerr++;
        $display("FAIL w8_cycle t=%0t: busy=%b done=%b product=%h, required busy=%b done=%b product=%h",
                 $time, busy8, done8, product8, mb[1], md[1], mp[1][15:0]);
      end
    end
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic fire16(bit sm, logic [15:0] m, logic [15:0] q);
    s16 = 1'b1; sm16 = sm; m16 = m; q16 = q;
    @(posedge clk); #1;
    s16 = 1'b0; m16 = 16'($urandom); q16 = 16'($urandom);
  endtask

  task automatic wait16(output int c);
    c = 0;
    do begin
      @(posedge clk); #1;
      c++;
    end while (!done16 && c < 200);
  endtask

  int c;
  bit saw;
`ifdef BOOTH_RADIX4_EN
  localparam int LS = 8, LU = 9;
`else
  localparam int LS = 16, LU = 17;
`endif

  initial begin
    rst = 1'b1;
    s16 = 0; sm16 = 0; m16 = '0; q16 = '0;
    s8 = 0; sm8 = 0; m8 = '0; q8 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1;
    chk("reset_busy", 64'(busy16), 64'd0);
    chk("reset_done", 64'(done16), 64'd0);
    chk("reset_product", 64'(product16), 64'd0);
    rst = 1'b0;

    chk("model_3x-5", mulx(16, 1, 64'd3, 64'hFFFB), 64'hFFFFFFF1);
    chk("model_u8_ffxff", mulx(8, 0, 64'hFF, 64'hFF), 64'hFE01);
    chk("model_s8_80x80", mulx(8, 1, 64'h80, 64'h80), 64'h4000);

    fire16(1, 16'd3, 16'hFFFB);
    wait16(c);
    chk("lat_signed", 64'(c), 64'(LS));
    chk("prod_3x-5", 64'(product16), 64'hFFFFFFF1);

    repeat (2) @(posedge clk); #1;
    fire16(1, 16'h8000, 16'h8000);
    wait16(c);
    chk("prod_min_x_min", 64'(product16), 64'h40000000);
    fire16(1, 16'h8000, 16'h7FFF);
    wait16(c);
    chk("prod_min_x_max", 64'(product16), 64'hC0008000);

    repeat (1) @(posedge clk); #1;
    fire16(0, 16'hFFFF, 16'hFFFF);
    wait16(c);
    chk("lat_unsigned", 64'(c), 64'(LU));
    chk("prod_uffff_sq", 64'(product16), 64'hFFFE0001);

    repeat (3) @(posedge clk); #1;
    fire16(1, 16'd7, 16'd9);
    repeat (4) @(posedge clk);
    #1; s16 = 1'b1; m16 = 16'd1234; q16 = 16'd5678;
    @(posedge clk); #1; s16 = 1'b0;
    wait16(c);
    chk("lat_midrun_start", 64'(c), 64'(LS - 5));
    chk("prod_midrun_start", 64'(product16), 64'd63);
    fire16(1, 16'hFFFE, 16'h0100);
    wait16(c);
    chk("lat_back_to_back", 64'(c), 64'(LS));
    chk("prod_back_to_back", 64'(product16), 64'hFFFFFE00);

    repeat (2) @(posedge clk); #1;
    fire16(1, 16'd100, 16'd100);
    repeat (4) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_busy", 64'(busy16), 64'd0);
    chk("rst_mid_done", 64'(done16), 64'd0);
    chk("rst_mid_product", 64'(product16), 64'd0);
    rst = 1'b0;
    saw = 0;
    repeat (LS + 4) begin
      @(posedge clk); #1;
      if (done16) saw = 1;
    end
    chk("no_done_after_rst", 64'(saw), 64'd0);
    fire16(0, 16'h1234, 16'h0010);
    wait16(c);
    chk("prod_after_rst", 64'(product16), 64'h12340);

    for (int k = 0; k < 15000; k++) begin
      @(negedge clk);
      s8  = ($urandom % 3) == 0;
      sm8 = $urandom % 2;
      m8  = (($urandom % 6) == 0) ? 8'h80 : 8'($urandom);
      q8  = (($urandom % 6) == 0) ? 8'h80 : 8'($urandom);
    end
    @(negedge clk); s8 = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("w8_ops_ge_1000", 64'(ncomp8 >= 1000), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/booth_mult_param.md
Name: booth_mult_param

Overview:
- Parametrised, iterative Booth multiplier; next generation of the team's fixed 16-bit serial-load Booth unit.
- Operands are loaded in parallel on a start pulse, so there is no multi-cycle load sequence. Signed and unsigned modes are supported.
- Produces a full 2*WIDTH product with a one-cycle done pulse.
- Sits beside the datapath as a shared multi-cycle arithmetic resource; single clock domain.

Parameters:
- WIDTH, 16, operand width in bits; legal range 4..64. Elaboration error outside that range.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request; accepted only when busy=0 or done=1
- signed_mode  input  1  1 = two's-complement operands; 0 = unsigned operands; sampled with start
- multiplicand  input  WIDTH  M operand, sampled on accept
- multiplier  input  WIDTH  Q operand, sampled on accept
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; product valid
- product  output  2*WIDTH  result; held until the next accept

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, product=0, counter=0. Reset has priority over everything, including mid-operation; a reset operation produces no done pulse.
- Internal width N: N=WIDTH if signed_mode=1; N=WIDTH+1 if signed_mode=0.
- In unsigned mode, operands are zero-extended by one bit. All internal arithmetic is N-bit two's complement.
- Registers: A (N bits), Q (N bits), qm1 (1 bit), M (N bits), count (ceil(log2(WIDTH+2)) bits).
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
  - DONE: done=1 for exactly one cycle, busy=0.
  - DONE then returns to IDLE, or to RUN on a back-to-back accept.
- Accept (edge E0, start=1 and state IDLE or DONE): A<=0, Q<=ext(multiplier), qm1<=0, M<=ext(multiplicand), count<=N, state<=RUN.
- RUN iteration, one per clock edge:
  - {Q[0],qm1}=01: A<=A+M.
  - {Q[0],qm1}=10: A<=A-M.
  - 00 or 11: A unchanged.
  - Then arithmetic right shift of {A,Q,qm1} by 1, with the sign of the post-add A replicated. count<=count-1.
- On the edge where the last iteration completes (count 1 to 0):
  - product<=low 2*WIDTH bits of {A,Q} after the shift.
  - done<=1, busy<=0, state<=DONE.
- Latency: done rises N edges after the accept edge, i.e. WIDTH cycles (signed) or WIDTH+1 cycles (unsigned).
- Throughput: start asserted in the DONE cycle is accepted, giving back-to-back operation with no idle bubble. done drops at that edge and busy rises.
- start while in RUN is ignored. The operand inputs are don't-care outside the accept edge.
- product changes only on the completion edge and on reset. It is not cleared on a new accept.
- Edge cases:
  - Most-negative × most-negative in signed mode gives the exact positive result. No overflow is possible because the product is 2*WIDTH bits.
  - Multiplication by 0 still takes the full latency.

Optional Feature:
- Macro: BOOTH_RADIX4_EN.
- Defined: RUN uses radix-4 modified Booth recoding.
  - Operands are sign-extended to an even width N'=N+(N mod 2).
  - Each iteration examines {Q[1],Q[0],qm1} and selects 0, ±M or ±2M, then arithmetic-shifts right by 2.
  - Iteration count is N'/2, so latency is N'/2 cycles; 8 cycles for WIDTH=16 in signed mode.
  - A is widened by 1 bit internally to hold 2M.
  - All handshake rules, port behaviour and product values are unchanged.
- Undefined: radix-2 only, as described above.

Test Plan:
- WIDTH=16, signed_mode=1, M=3, Q=-5 (0xFFFB) -> done exactly 16 cycles after accept, product=0xFFFFFFF1, busy high for those 16 cycles. With BOOTH_RADIX4_EN, done after 8 cycles.
- WIDTH=16, signed_mode=1, M=Q=0x8000 -> product=0x40000000. Same operands with M=0x8000, Q=0x7FFF -> product=0xC0008000.
- WIDTH=16, signed_mode=0, M=Q=0xFFFF -> product=0xFFFE0001, done at 17 cycles. With BOOTH_RADIX4_EN, done at 9 cycles.
- start pulsed mid-RUN with different operands -> ignored; first result correct and unchanged. start held during the DONE cycle -> second op accepted, its done follows exactly N cycles later, no extra bubble.
- rst asserted 5 cycles into RUN -> next edge busy=0, done=0, product=0, and no done pulse appears. A new start afterward completes correctly.
- WIDTH=8 instance, random signed/unsigned operands (≥1000) against a reference model -> all products match. done is a single-cycle pulse each time, and product is stable between completions.
